// File: rtl/pg_alu_domain.sv
// Power-gated multi-cycle ALU with its own power/isolation sequencer.
// Optional PGA_RETENTION_EN keeps the last result visible while the domain is off.
module pg_alu_domain #(
    parameter int             W          = 16,
    parameter int             PUP_CYCLES = 4,
    parameter logic [W-1:0]   CLAMP_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pwr_req,
    input  logic         start,
    input  logic [3:0]   opcode,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         start_rej,
    output logic         pwr_ack,
    output logic         alu_pwr_en,
    output logic         iso_en
);

    localparam int SW  = $clog2(W);
    localparam int PCW = (PUP_CYCLES > 1) ? $clog2(PUP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_PUP,
        S_ON,
        S_DRAIN,
        S_ISO
    } pst_e;

    pst_e           state_q, state_d;
    logic [PCW-1:0] pcnt_q;
    logic           pwr_en_q, iso_q, ack_q;

    logic [W-1:0]   alu_q, acc_q, mc_q, mp_q;
    logic [SW-1:0]  cnt_q;
    logic           busy_q, done_q, rej_q, mul_q;

    logic [W-1:0]   op_res, acc_nx, clamp_src;
    logic [SW-1:0]  shamt;
    logic           accept;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OFF:   if (pwr_req) state_d = S_PUP;
            S_PUP:   if (pcnt_q == '0) state_d = S_ON;
            S_ON:    if (!pwr_req) state_d = S_DRAIN;
            S_DRAIN: if (!busy_q) state_d = S_ISO;
            S_ISO:   state_d = S_OFF;
            default: state_d = S_OFF;
        endcase
    end

    // Power controls are registered from the next state so they track state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            pcnt_q   <= '0;
            pwr_en_q <= 1'b0;
            iso_q    <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (state_q != S_PUP) pcnt_q <= PCW'(PUP_CYCLES - 1);
            else                  pcnt_q <= pcnt_q - 1'b1;
            pwr_en_q <= (state_d != S_OFF);
            iso_q    <= (state_d == S_OFF) || (state_d == S_PUP)
                     || (state_d == S_ISO);
            ack_q    <= (state_d == S_ON);
        end
    end

    assign shamt  = B[SW-1:0];
    assign accept = start && (state_q == S_ON) && (!busy_q || done_q);
    assign acc_nx = acc_q + (mp_q[0] ? mc_q : '0);

    always_comb begin
        op_res = '0;
        unique case (opcode)
            4'd0:    op_res = A + B;
            4'd1:    op_res = A - B;
            4'd2:    op_res = A & B;
            4'd3:    op_res = A | B;
            4'd4:    op_res = A ^ B;
            4'd5:    op_res = ~A;
            4'd6:    op_res = A << shamt;
            4'd7:    op_res = A >> shamt;
            default: op_res = '0;
        endcase
    end

    // MUL: first partial product is folded into the accept edge so the
    // W-th step lands on the cycle done pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_q  <= '0;
            acc_q  <= '0;
            mc_q   <= '0;
            mp_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rej_q  <= 1'b0;
            mul_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rej_q  <= start && !accept;
            if (!pwr_en_q) begin
                alu_q  <= '0;
                busy_q <= 1'b0;
                mul_q  <= 1'b0;
            end else if (accept) begin
                busy_q <= 1'b1;
                if (opcode == 4'd8) begin
                    mul_q <= 1'b1;
                    cnt_q <= SW'(W - 1);
                    acc_q <= B[0] ? A : '0;
                    mc_q  <= A << 1;
                    mp_q  <= B >> 1;
                end else begin
                    alu_q  <= op_res;
                    done_q <= 1'b1;
                end
            end else if (mul_q) begin
                acc_q <= acc_nx;
                mc_q  <= mc_q << 1;
                mp_q  <= mp_q >> 1;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == SW'(1)) begin
                    alu_q  <= acc_nx;
                    done_q <= 1'b1;
                    mul_q  <= 1'b0;
                end
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef PGA_RETENTION_EN
    logic [W-1:0] ret_q;
    logic         dirty_q;

    // Only a session that produced a result overwrites the retained value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_q   <= CLAMP_VAL;
            dirty_q <= 1'b0;
        end else begin
            if (!pwr_en_q) dirty_q <= 1'b0;
            else if (done_q) dirty_q <= 1'b1;
            if (state_q == S_DRAIN && state_d == S_ISO && dirty_q)
                ret_q <= alu_q;
        end
    end

    assign clamp_src = ret_q;
`else
    assign clamp_src = CLAMP_VAL;
`endif

    assign result     = (iso_q || !pwr_en_q) ? clamp_src : alu_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign start_rej  = rej_q;
    assign pwr_ack    = ack_q;
    assign alu_pwr_en = pwr_en_q;
    assign iso_en     = iso_q;

endmodule
